// File: rtl/type_pkg.sv
// Shared datapath types for the register file slice.
// NREGS-dependent address widths are derived inside each module.
package type_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [4:0]      reg_addr_t;

endpackage : type_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: alloc sets a bit, any write-back clears it,
// and a set in the same cycle as a clear wins. Register 0 is never pending.
module regfile_scoreboard
    import type_pkg::*;
#(
    parameter int NWR   = 2,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en      [NWR],
    input  logic [AW-1:0]    wr_addr    [NWR],
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_vec;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                busy_nxt[wr_addr[w]] = 1'b0;
            end
        end
        // Applied after the clears so a new producer overrides a retiring one.
        if (alloc_en) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-ported register file with optional same-cycle write forwarding and
// a pending-producer scoreboard. Register 0 is hardwired to zero.
module regfile_mp
    import type_pkg::*;
#(
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr    [NRD],
    output data_t            rd_data    [NRD],
    output logic             rd_busy    [NRD],
    input  logic             wr_en      [NWR],
    input  logic [AW-1:0]    wr_addr    [NWR],
    input  data_t            wr_data    [NWR],
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    output logic [NREGS-1:0] busy_vec
);

    data_t regs [NREGS];

    // Later ports are applied last, so the highest index wins on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w] != '0)) begin
                    regs[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NWR   (NWR),
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec)
    );

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic  hit;
        data_t fwd;
        logic  fwd_ok;

        always_comb begin
            hit = 1'b0;
            fwd = '0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w] == rd_addr[r])) begin
                    hit = 1'b1;
                    fwd = wr_data[w];
                end
            end
        end

        assign fwd_ok = (BYPASS != 0) && hit;

        // Address 0 is checked first so x0 never forwards or reports busy.
        always_comb begin
            if (rd_addr[r] == '0) begin
                rd_data[r] = '0;
                rd_busy[r] = 1'b0;
            end else if (fwd_ok) begin
                rd_data[r] = fwd;
                rd_busy[r] = 1'b0;
            end else begin
                rd_data[r] = regs[rd_addr[r]];
                rd_busy[r] = busy_vec[rd_addr[r]];
            end
        end
    end

endmodule : regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001: Parameter NRD, default 2, SHALL set the number of read ports (1..4).
REQ-002: Parameter NWR, default 2, SHALL set the number of write ports (1..2).
REQ-003: Parameter NREGS, default 32, SHALL set the architectural register count (power of two, 8..64).
REQ-004: Parameter BYPASS, default 1, SHALL enable same-cycle write-to-read forwarding when 1.
REQ-005: The port clk, input, 1 bit, SHALL be the single clock; every state element updates on its rising edge.
REQ-006: The port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-007: The port rd_addr[NRD], input, $clog2(NREGS) bits each, SHALL carry the read register numbers.
REQ-008: The port rd_data[NRD], output, XLEN bits each, SHALL carry the read data.
REQ-009: The port rd_busy[NRD], output, 1 bit each, SHALL be high when the read register has a pending producer and no forwarded value.
REQ-010: The ports wr_en[NWR], input, 1 bit each; wr_addr[NWR], input, $clog2(NREGS) bits each; and wr_data[NWR], input, XLEN bits each, SHALL form the write-back ports.
REQ-011: The ports alloc_en, input, 1 bit, and alloc_addr, input, $clog2(NREGS) bits, SHALL mark the destination of a newly issued instruction as pending.
REQ-012: The port busy_vec, output, NREGS bits, SHALL expose the scoreboard state directly.

Function
REQ-013: Register 0 SHALL always read 0 with rd_busy low; writes and allocs to it SHALL be ignored.
REQ-014: Reads SHALL be combinational, with 0-cycle latency from rd_addr to rd_data.
REQ-015: Writes SHALL commit at the rising edge, so the value is visible to reads in the next cycle.
REQ-016: With BYPASS=1, a read SHALL return wr_data in the same cycle when a wr_en port targets the same nonzero address.
REQ-017: With BYPASS=1, rd_busy SHALL be low in that same-address write cycle.
REQ-018: With BYPASS=0, a same-cycle write SHALL NOT forward, and rd_busy SHALL follow busy_vec.
REQ-019: When multiple write ports target the same address in one cycle, the highest-index port SHALL win for both the commit and the forwarded value.
REQ-020: Each scoreboard bit SHALL be set by alloc_en at the edge and cleared by any wr_en to that address at the edge.
REQ-021: When alloc and write-back hit the same register in one cycle, the set SHALL win (new producer) and the written data SHALL still commit.
REQ-022: An alloc to a register that is already busy SHALL leave it busy, with no error.
REQ-023: A write to a register that is not busy SHALL commit normally, with busy staying 0.
REQ-024: Address arithmetic SHALL be unsigned; addresses at or above NREGS cannot occur by width construction.

Reset
REQ-025: While rst is high at a clock edge, all registers SHALL clear to 0 and busy_vec SHALL clear to 0, ignoring writes and allocs in that cycle.
REQ-026: After reset, rd_data SHALL be 0 and rd_busy low for every address, apart from combinational forwarding of same-cycle writes when BYPASS=1.
REQ-027: A reset asserted while registers are pending SHALL drop all pending state, and later write-backs to those registers SHALL commit as ordinary writes.
REQ-028: The design SHALL contain no initial blocks; reset SHALL be the only initialisation.

Structure
REQ-029: data_t, reg_addr_t and XLEN SHALL come from type_pkg, and NREGS-dependent widths SHALL be derived locally.
REQ-030: The scoreboard SHALL be a sub-module regfile_scoreboard (set/clear/priority logic, busy_vec output).
REQ-031: Storage, the write-port priority and forwarding SHALL remain in regfile_mp.

Verification
REQ-032: The bench SHALL cover this scenario: rst high 1 cycle, then read x0..x31 -> all 0 and busy_vec=0.
REQ-033: The bench SHALL cover this scenario: write x5=0xDEADBEEF on port 0 while reading x5 in the same cycle -> BYPASS=1 reads 0xDEADBEEF that cycle; BYPASS=0 reads 0 then 0xDEADBEEF next cycle.
REQ-034: The bench SHALL cover this scenario: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle -> x7 reads 0x22 afterwards.
REQ-035: The bench SHALL cover this scenario: alloc x3, then read x3 -> rd_busy=1; write x3=0x40 -> bypass read 0x40 with busy 0, and busy_vec[3]=0 next cycle.
REQ-036: The bench SHALL cover this scenario: alloc x9 and write x9=0x55 in the same cycle -> busy_vec[9]=1 and x9 reads 0x55 with rd_busy=1.
REQ-037: The bench SHALL cover this scenario: alloc x0 and write x0=0xFF -> x0 reads 0 and busy_vec[0]=0; rst mid-pending (x4 busy) -> busy_vec=0 next cycle.
